// File: rtl/wb_arbiter_if.sv
// Five-unit result request bus plus registered writeback port.
// The slave modport is the arbiter's view; the master modport is the units/regfile side.
interface wb_arbiter_if #(
  parameter int RB = 2,
  parameter int DW = 64
);
  localparam int TW = 5 + RB;

  logic [4:0]      req_valid;
  logic [5*TW-1:0] req_rd0;
  logic [5*DW-1:0] req_res;
  logic [4:0]      req_ready;
  logic            wb_valid;
  logic [TW-1:0]   wb_rd0;
  logic [DW-1:0]   wb_res;
  logic            wb_stall;

  modport slave (
    input  req_valid, req_rd0, req_res, wb_stall,
    output req_ready, wb_valid, wb_rd0, wb_res
  );

  modport master (
    output req_valid, req_rd0, req_res, wb_stall,
    input  req_ready, wb_valid, wb_rd0, wb_res
  );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one writeback port among alu/bru/lsu/csr/mul; grant to wb_valid is 1 cycle.
// wb_stall holds the output register and withholds grants; flush drops the pending writeback.
module wb_arbiter #(
  parameter int RB = 2,
  parameter int DW = 64
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        flush,
  wb_arbiter_if.slave bus
);
  localparam int NU = 5;
  localparam int TW = 5 + RB;

  logic [2:0]    ptr_q, ptr_d;
  logic          wb_valid_q, wb_valid_d;
  logic [TW-1:0] wb_rd0_q, wb_rd0_d;
  logic [DW-1:0] wb_res_q, wb_res_d;

  logic          slot_free;
  logic          gnt_any;
  logic [2:0]    gnt_idx;
  logic [2:0]    cand;
  logic [NU-1:0] gnt_oh;
  logic [TW-1:0] rd_slot  [NU];
  logic [DW-1:0] res_slot [NU];

  // Modulo-5 add; base is always a legal unit index, so one subtraction suffices.
  function automatic logic [2:0] wrap_add(input logic [2:0] base, input logic [2:0] off);
    logic [3:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 4'd5) s = s - 4'd5;
    return s[2:0];
  endfunction

  assign slot_free = ~wb_valid_q | ~bus.wb_stall;

  always_comb begin
    for (int i = 0; i < NU; i++) begin
      rd_slot[i]  = bus.req_rd0[i*TW +: TW];
      res_slot[i] = bus.req_res[i*DW +: DW];
    end
  end

  // Grant depends only on valids, pointer and output-slot state, never on payload.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    cand    = '0;
    if (slot_free && !flush) begin
      for (int k = 0; k < NU; k++) begin
        cand = wrap_add(ptr_q, 3'(k));
        if (!gnt_any && bus.req_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d      = ptr_q;
    wb_valid_d = wb_valid_q;
    wb_rd0_d   = wb_rd0_q;
    wb_res_d   = wb_res_q;
    if (flush) begin
      wb_valid_d = 1'b0;
    end else if (gnt_any) begin
      wb_valid_d = 1'b1;
      wb_rd0_d   = rd_slot[gnt_idx];
      wb_res_d   = res_slot[gnt_idx];
      ptr_d      = wrap_add(gnt_idx, 3'd1);
    end else if (slot_free) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ptr_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd0_q   <= '0;
      wb_res_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wb_valid_q <= wb_valid_d;
      wb_rd0_q   <= wb_rd0_d;
      wb_res_q   <= wb_res_d;
    end
  end

  assign bus.req_ready = gnt_oh;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_rd0    = wb_rd0_q;
  assign bus.wb_res    = wb_res_q;

  a_gnt_onehot: assert property (@(posedge CLK) disable iff (!RSTn) $onehot0(gnt_oh));
  a_gnt_in_req: assert property (@(posedge CLK) disable iff (!RSTn) (gnt_oh & ~bus.req_valid) == '0);
  a_ptr_range:  assert property (@(posedge CLK) disable iff (!RSTn) ptr_q < 3'd5);
  a_stall_hold: assert property (@(posedge CLK) disable iff (!RSTn)
                  (wb_valid_q && bus.wb_stall && !flush) |=> (wb_valid_q && $stable(wb_rd0_q) && $stable(wb_res_q)));
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter RB, default 2, rename-copy index bits; physical register tag width is 5+RB.
REQ-002 SHALL have parameter DW, default 64, result data width.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RSTn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  pipeline flush; drops any pending writeback.
REQ-006 SHALL have port req_valid  input  5  per-unit result valid; bit0 alu, 1 bru, 2 lsu, 3 csr, 4 mul.
REQ-007 SHALL have port req_rd0  input  5*(5+RB)  per-unit destination tag; unit i occupies slice [i*(5+RB) +: 5+RB].
REQ-008 SHALL have port req_res  input  5*DW  per-unit result; unit i occupies slice [i*DW +: DW].
REQ-009 SHALL have port req_ready  output  5  one-hot grant; unit i's result is consumed when req_valid[i] & req_ready[i].
REQ-010 SHALL have port wb_valid  output  1  registered writeback valid to regfile/rename commit.
REQ-011 SHALL have port wb_rd0  output  5+RB  registered writeback tag.
REQ-012 SHALL have port wb_res  output  DW  registered writeback data.
REQ-013 SHALL have port wb_stall  input  1  regfile cannot accept this cycle; output stage holds.

Function
REQ-014 SHALL share one writeback port among 5 units by round-robin arbitration, using a 3-bit pointer ptr in range 0..4.
REQ-015 SHALL compute slot_free = ~wb_valid | ~wb_stall each cycle.
REQ-016 SHALL grant, when slot_free & ~flush, the first unit with req_valid set, searching ptr, ptr+1, ... modulo 5; req_ready SHALL be one-hot or zero.
REQ-017 SHALL drive req_ready to all-zero when slot_free=0, flush=1, or no req_valid is set.
REQ-018 SHALL make req_ready combinational from req_valid, ptr, wb_valid, wb_stall and flush, with no dependence on req_rd0 or req_res.
REQ-019 SHALL, on a grant to unit g, load wb_rd0/wb_res from slice g and set wb_valid=1 at the next edge; grant-to-wb_valid latency is 1 cycle.
REQ-020 SHALL set ptr to (g+1) mod 5 after a grant to unit g, with 4 wrapping to 0; ptr SHALL be unchanged in cycles with no grant.
REQ-021 SHALL hold wb_valid, wb_rd0 and wb_res stable while wb_valid & wb_stall & ~flush.
REQ-022 SHALL clear wb_valid at the next edge when slot_free & no grant & ~flush; wb_rd0/wb_res keep their last values.
REQ-023 SHALL clear wb_valid at the next edge on flush=1 regardless of wb_stall, grant nothing in that cycle, and leave ptr unchanged.
REQ-024 SHALL sustain one writeback per cycle back-to-back when wb_stall=0 and requests are continuous.
REQ-025 SHALL guarantee that any continuously asserted req_valid[i] is granted within 5 free-slot cycles (no starvation).
REQ-026 SHALL leave req_valid/req_ready handshake semantics to the requester: a unit keeps req_valid and its data stable until granted.

Reset
REQ-027 SHALL, while RSTn=0, asynchronously force wb_valid=0, wb_rd0=0, wb_res=0, ptr=0; req_ready SHALL then equal the arbitration of req_valid with ptr=0 and wb_valid=0.
REQ-028 SHALL, on reset asserted mid-stall, discard the held writeback; after release the first grant SHALL search from unit 0.

Verification
REQ-029 SHALL cover: after reset, req_valid=5'b10110 -> req_ready=5'b00010; next cycle wb_valid=1 with bru data, ptr=2.
REQ-030 SHALL cover: all 5 units valid continuously, wb_stall=0 -> grants 0,1,2,3,4,0 on consecutive cycles, one wb_valid per cycle.
REQ-031 SHALL cover: wb_valid=1, wb_stall=1 for 3 cycles with req_valid=5'b00001 -> req_ready=0 and wb_rd0/wb_res unchanged; grant on the cycle wb_stall drops.
REQ-032 SHALL cover: ptr=4 with req_valid=5'b10001 -> grant unit 4, then ptr wraps to 0 and unit 0 is granted next.
REQ-033 SHALL cover: flush=1 while wb_valid=1, wb_stall=1 and req_valid=5'b11111 -> req_ready=0, wb_valid=0 next cycle, ptr unchanged.
REQ-034 SHALL cover: RSTn pulsed low during a stalled writeback -> wb_valid=0 immediately (asynchronous), ptr=0 after release.
